// File: rtl/apb_mem_pkg.sv
// Shared types and elaboration helpers for the APB memory slave.
// Holds the FSM state encoding and parameter legality checks.
package apb_mem_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  function automatic int align_f(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic bit params_ok(
    input int aw,
    input int dw,
    input int depth,
    input int waits,
    input int ro
  );
    bit ok;
    ok = (dw == 8 || dw == 16 || dw == 32 || dw == 64);
    ok = ok && depth >= 2 && (depth & (depth - 1)) == 0;
    ok = ok && waits >= 0 && waits <= 15;
    ok = ok && ro >= 0 && ro <= depth;
    ok = ok && aw > $clog2(depth) + align_f(dw);
    return ok;
  endfunction

endpackage

// File: rtl/apb_mem_slave_p_if.sv
// APB4 bus bundle between a master and the memory slave.
// Clock and reset travel as plain ports alongside it.
interface apb_mem_slave_p_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import apb_mem_pkg::*;

  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_mem_array.sv
// Word storage with byte-lane synchronous write and async read.
// Contents are intentionally not reset.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int IW        = $clog2(DEPTH),
  localparam int NB        = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IW-1:0]         widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [NB-1:0]         strb,
  input  logic [IW-1:0]         ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (strb[i]) mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_mem_slave_p.sv
// APB4 memory slave: wait states, byte strobes, read-only low region.
// All bus outputs come straight from registers.
module apb_mem_slave_p
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int RO_WORDS    = 0
) (
  input  logic             pclk,
  input  logic             presetn,
  apb_mem_slave_p_if.slave bus
);

  localparam int ALIGN = align_f(DATA_WIDTH);
  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WC = CW'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << ALIGN) - 1);

  if (!params_ok(ADDR_WIDTH, DATA_WIDTH, DEPTH, WAIT_CYCLES, RO_WORDS))
  begin : g_bad_params
    $error("apb_mem_slave_p: illegal parameter combination");
  end

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx_q;
  logic                  wr_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;

  logic [ADDR_WIDTH-1:0] word;
  logic                  misalign;
  logic                  out_range;
  logic                  prot;
  logic                  err;
  logic                  last;
  logic                  we;
  logic [DATA_WIDTH-1:0] rdata;

  assign word      = bus.paddr >> ALIGN;
  assign out_range = word >= ADDR_WIDTH'(DEPTH);

  if (ALIGN == 0) begin : g_no_align
    assign misalign = 1'b0;
  end else begin : g_align
    assign misalign = (bus.paddr & LOW_MASK) != '0;
  end

  if (RO_WORDS == 0) begin : g_no_ro
    assign prot = 1'b0;
  end else begin : g_ro
    assign prot = bus.pwrite && (word < ADDR_WIDTH'(RO_WORDS));
  end

  assign err  = misalign || out_range || prot;
  assign last = (cnt == WC);
  assign we   = (state == ACCESS) && bus.psel && bus.penable
             && last && wr_q && !err_q;

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (pclk),
    .we    (we),
    .widx  (idx_q),
    .wdata (bus.pwdata),
    .strb  (bus.pstrb),
    .ridx  (word[IW-1:0]),
    .rdata (rdata)
  );

  // pready rises on the edge entering the final access cycle
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.psel && !bus.penable) begin
            state     <= ACCESS;
            cnt       <= '0;
            idx_q     <= word[IW-1:0];
            wr_q      <= bus.pwrite;
            err_q     <= err;
            prdata_q  <= (err || bus.pwrite) ? '0 : rdata;
            pready_q  <= (WC == '0);
            pslverr_q <= (WC == '0) && err;
          end
        end
        ACCESS: begin
          if (bus.psel && bus.penable) begin
            if (!last) begin
              cnt <= cnt + CW'(1);
              if (cnt + CW'(1) == WC) begin
                pready_q  <= 1'b1;
                pslverr_q <= err_q;
              end
            end else begin
              state     <= IDLE;
              pready_q  <= 1'b0;
              pslverr_q <= 1'b0;
            end
          end else begin
            state     <= IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule

// File: doc/apb_mem_slave_p.md
# apb_mem_slave_p

Parametrised APB4 memory-mapped slave with configurable data width, depth, programmable wait states, byte-lane write strobes and a read-only low region. It replaces the fixed 16x8 APB test memory as the standard storage target on the verification APB bus. All outputs are registered. Error responses are returned for misaligned, out-of-range and protected accesses.

## Interface
- ADDR_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, data bus width; legal values 8/16/32/64.
- DEPTH, 16, number of DATA_WIDTH words; power of two, at least 2.
- WAIT_CYCLES, 0, wait states inserted in every access phase before pready; 0..15.
- RO_WORDS, 0, words 0..RO_WORDS-1 are read-only; must be at most DEPTH.
- pclk  in  1  clock.
- presetn  in  1  reset, asynchronous, active-low.
- paddr  in  ADDR_WIDTH  byte address.
- psel  in  1  slave select.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte-lane strobes.
- prdata  out  DATA_WIDTH  read data, registered.
- pready  out  1  transfer complete, registered.
- pslverr  out  1  error response, registered; meaningful only while pready=1.

## Operation
- ALIGN = log2(DATA_WIDTH/8). Word index = paddr[ADDR_WIDTH-1:ALIGN].
- Error conditions, evaluated at the setup edge:
  - misaligned: paddr[ALIGN-1:0] != 0 (never applies when DATA_WIDTH=8);
  - out of range: index >= DEPTH, compared over all upper bits;
  - protected: pwrite=1 and index < RO_WORDS.
- An erroring transfer never modifies memory. It returns prdata=0 and pslverr=1 with pready.
- Write: only lanes with pstrb[i]=1 are updated. pstrb=0 is a legal no-op with no error.
- Read: pstrb is ignored. prdata holds the full word.
- Memory contents are not reset. prdata holds its last value between transfers.
- FSM states are IDLE and ACCESS, plus a wait counter `cnt` of width clog2(WAIT_CYCLES+1).
  - IDLE: psel=1 and penable=0 at an edge → ACCESS, cnt=0, latch address/pwrite/error flag, load prdata (mem[index], or 0 on error or write).
  - ACCESS with psel=1 and penable=1: if cnt<WAIT_CYCLES then cnt++; else this is the completion cycle. Commit the write at the edge ending it, then → IDLE.
  - ACCESS with psel=0 or penable=0: protocol abort. → IDLE, no write, pready/pslverr cleared at that edge.
- Address, control, pwdata and pstrb are sampled for the write at the completion edge. APB requires them to be stable, so no checking is done.

## Timing
- Reset: state=IDLE, cnt=0, prdata=0, pready=0, pslverr=0. Reset mid-transfer aborts it and the pending write is lost.
- pready is a register. It is set at the edge that enters the final access cycle and cleared at the completion edge. It is high for exactly one cycle per transfer.
- With WAIT_CYCLES=0, pready=1 in the first access cycle, giving a 2-cycle transfer.
- In general a transfer takes 2+WAIT_CYCLES cycles from setup to completion.
- pslverr follows the same timing as pready and is always 0 while pready=0.
- Back-to-back: a new setup cycle may immediately follow the completion cycle. That read observes the write just committed.
- No pipelining: one outstanding transfer at a time.

## Structure
- Package apb_mem_pkg holds:
  - the state_t enum {IDLE, ACCESS};
  - an ALIGN function (log2 of byte lanes);
  - parameter-legality checks, as an elaboration-time assertion function.
- Sub-module apb_mem_array holds the storage: DEPTH x DATA_WIDTH, byte-enable synchronous write, asynchronous read index with registered capture in the parent. The FSM, error decode and wait counter stay in apb_mem_slave_p.

## Test plan
Scenarios 1-4 use DATA_WIDTH=32, DEPTH=16, WAIT_CYCLES=2, RO_WORDS=2.
1. Write 0xDEADBEEF to 0x08 with pstrb=0xF, then read 0x08 → pready high on the 4th cycle of each transfer, pslverr=0, prdata=0xDEADBEEF.
2. Write 0x11223344 to 0x0C with pstrb=0xF, then write 0xAABBCCDD with pstrb=0x5, then read 0x0C → prdata=0x11BB33DD.
3. Write to 0x04 (protected), then read 0x04, read 0x40 (out of range) and read 0x09 (misaligned) → the write gets pslverr=1 and the read of 0x04 returns the pre-write contents unchanged; the reads of 0x40 and 0x09 get pslverr=1 and prdata=0.
4. Drop penable in the 2nd wait cycle of a write of 0x55 to 0x10, then read 0x10 → the aborted write never gets pready, and the read returns the old contents.
5. WAIT_CYCLES=0, DATA_WIDTH=8: back-to-back write 0xA5 to 0x3, then read 0x3 → each transfer takes 2 cycles, prdata=0xA5.
6. Assert presetn low during the access phase of a write → outputs go to 0 immediately, state=IDLE, and memory is unchanged.
